load_store_unit: RTL

Data-memory access stage between the ALU/branch datapath and the word-wide data memory. It takes the ALU-computed address, the store data and the funct3 access size. It generates word-aligned memory requests with byte enables and replicated store lanes, and runs a req/gnt/rvalid handshake with a timeout. It returns sign- or zero-extended load data and stalls the pipeline while the access is in flight.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/lsu_align.sv | 77 +++++++
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the data-memory access path.
//   lsu_size_e  : funct3 access size encodings (B, H, W, BU, HU)
//   lsu_state_e : load/store unit handshake states
//   WORD_BYTES  : byte lanes per memory word
package riscv_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for word-wide data memory accesses.
// Ports:
//   size_i       funct3 access size
//   addr_lo_i    byte offset within the word (addr[1:0])
//   wdata_i      raw store data (rs2)
//   rdata_i      raw word read from memory
//   be_o         byte enables for the access
//   wdata_o      store data replicated across the addressed lanes
//   rdata_o      selected load data, sign- or zero-extended
//   misaligned_o halfword/word access not on its natural boundary
//   illegal_o    size encoding that is not a valid load size
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]            size_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [31:0]           wdata_i,
  input  logic [31:0]           rdata_i,
  output logic [WORD_BYTES-1:0] be_o,
  output logic [31:0]           wdata_o,
  output logic [31:0]           rdata_o,
  output logic                  misaligned_o,
  output logic                  illegal_o
);

  logic        [7:0]  byte_sel;
  logic        [15:0] half_sel;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
  end

  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  // Widening a signed operand through a size cast replicates its sign bit.
  assign byte_s  = signed'(byte_sel);
  assign half_s  = signed'(half_sel);
  assign byte_sx = 32'(byte_s);
  assign half_sx = 32'(half_s);

  always_comb begin
    be_o         = '0;
    wdata_o      = wdata_i;
    rdata_o      = rdata_i;
    misaligned_o = 1'b0;
    illegal_o    = 1'b0;
    case (size_i)
      SZ_B, SZ_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (size_i == SZ_B) ? unsigned'(byte_sx) : {24'b0, byte_sel};
      end
      SZ_H, SZ_HU: begin
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = (size_i == SZ_H) ? unsigned'(half_sx) : {16'b0, half_sel};
        misaligned_o = addr_lo_i[0];
      end
      SZ_W: begin
        be_o         = 4'b1111;
        misaligned_o = (addr_lo_i != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: turns an ALU address, store data and funct3
// size into a word-aligned req/gnt/rvalid memory transaction, returns the
// extended load data and stalls the pipeline while the access is in flight.
// Ports:
//   clk, rst       core clock, synchronous active-high reset
//   req_i          access request, held by the pipeline until done_o
//   we_i           1 = store, 0 = load
//   size_i         funct3 access size
//   addr_i         byte address
//   wdata_i        store data
//   rdata_o        extended load data (valid with done_o, no error)
//   done_o         one-cycle completion pulse
//   err_o          one-cycle error pulse with done_o
//   stall_o        request outstanding and not yet completing
//   mem_req_o ..   word-aligned memory request, write, byte enables,
//   mem_wdata_o    address and lane-replicated store data
//   mem_gnt_i      request accepted
//   mem_rvalid_i   read data valid
//   mem_rdata_i    read word
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  lsu_state_e  state_q;
  logic [7:0]  cnt_q;
  logic        mem_req_q;
  logic        done_q;
  logic        err_q;
  logic        we_q;

  logic [2:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] maddr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        in_idle;
  logic [2:0]  sel_size;
  logic [1:0]  sel_addr_lo;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] ext_rdata;
  logic        misaligned;
  logic        illegal;
  logic        bad_store;
  logic        access_err;
  logic        timeout;

  // In IDLE the lanes are computed from the incoming request; afterwards
  // the latched size/offset drive the load extraction.
  assign in_idle     = (state_q == ST_IDLE);
  assign sel_size    = in_idle ? size_i : size_q;
  assign sel_addr_lo = in_idle ? addr_i[1:0] : addr_lo_q;

  lsu_align u_align (
    .size_i       (sel_size),
    .addr_lo_i    (sel_addr_lo),
    .wdata_i      (wdata_i),
    .rdata_i      (mem_rdata_i),
    .be_o         (lane_be),
    .wdata_o      (lane_wdata),
    .rdata_o      (ext_rdata),
    .misaligned_o (misaligned),
    .illegal_o    (illegal)
  );

  // Unsigned sizes exist only for loads.
  assign bad_store  = we_i & ((size_i == SZ_BU) | (size_i == SZ_HU));
  assign access_err = illegal | misaligned | bad_store;
  // cnt_q counts completed REQ/WAIT cycles; this is the MAX_WAIT-th one.
  assign timeout    = (cnt_q == 8'(MAX_WAIT - 1));

  // Control FSM and timeout counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mem_req_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (req_i) begin
            we_q <= we_i;
            if (access_err) begin
              state_q <= ST_ERR;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q   <= ST_REQ;
              mem_req_q <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            if (we_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end else if (timeout) begin
            mem_req_q <= 1'b0;
            state_q   <= ST_ERR;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem_rvalid_i) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (timeout) begin
            state_q <= ST_ERR;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Request payload and returned load data
  always_ff @(posedge clk) begin
    if (in_idle && req_i) begin
      size_q    <= size_i;
      addr_lo_q <= addr_i[1:0];
      maddr_q   <= {addr_i[31:2], 2'b00};
      be_q      <= lane_be;
      wdata_q   <= lane_wdata;
    end
    if ((state_q == ST_WAIT) && mem_rvalid_i) begin
      rdata_q <= ext_rdata;
    end
  end

  // Payload registers carry no reset; registered control gates them so
  // every output reads zero after reset and outside its valid window.
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_req_q & we_q;
  assign mem_be_o    = mem_req_q ? be_q    : '0;
  assign mem_addr_o  = mem_req_q ? maddr_q : '0;
  assign mem_wdata_o = mem_req_q ? wdata_q : '0;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = (done_q & ~err_q & ~we_q) ? rdata_q : '0;
  assign stall_o     = req_i & ~done_q;

endmodule
